writeback_cache_way_seq: RTL
============================

// Module: writeback_cache_way_seq
// PURPOSE
//  Parametrised single way of a write-back set-associative data cache with built-in line
//  sequencing. Adds multi-beat line fill and dirty-line eviction streaming, plus per-set
//  invalidate, on top of combinational lookup and byte-masked hit writes.
//  Sits between the cache controller (issues start pulses, owns replacement) and the memory bus.
// PARAMETERS
//  LINES      256                               number of sets; power of 2, >=2
//  BLOCKSIZE  4                                 32-bit words per line; power of 2, >=2
//  TAGBITS    32-$clog2(LINES)-$clog2(BLOCKSIZE)-2   tag width; elaboration error if not equal
// PORTS
//  clk        in   1              clock, all state updates on rising edge
//  reset_n    in   1              asynchronous, active-low reset
//  A          in   32             lookup/write/start address: tag|set|word|byte
//  WD         in   32             CPU write data
//  ByteMask   in   4              CPU byte enables, bit i -> WD[8i+7:8i]
//  WE         in   1              CPU write request (takes effect on hit only)
//  Inval      in   1              invalidate set addressed by A
//  FillStart  in   1              start line fill at A (tag and set latched)
//  FillData   in   32             fill beat data
//  FillValid  in   1              fill beat valid
//  EvictStart in   1              start eviction of set addressed by A
//  EvictReady in   1              bus accepts current eviction beat
//  Hit        out  1              RV & (RTag == A tag field)
//  RV         out  1              valid bit of addressed set
//  Dirty      out  1              dirty bit of addressed set
//  RTag       out  TAGBITS        stored tag of addressed set
//  RD         out  32*BLOCKSIZE   full line, word 0 in bits [31:0]
//  RWord      out  32             word selected by A word field
//  Busy       out  1              high in FILL or EVICT
//  Done       out  1              one-cycle pulse after final fill/evict beat
//  EvictValid out  1              eviction beat valid
//  EvictData  out  32             eviction beat data
//  EvictAddr  out  32             {stored tag, latched set, beat index, 2'b00}
// BEHAVIOUR
//  - Fields: word A[ob+1:2], set A[ob+sb+1:ob+2], tag A[31:32-TAGBITS]; ob/sb = clog2(BLOCKSIZE/LINES).
//  - Lookup outputs combinational from A, always live (also while Busy).
//  - Reset: all V and dirty bits 0, FSM IDLE, Busy/Done/EvictValid 0, beat counter 0.
//    Data and tag arrays not reset. Reset mid-fill/evict aborts with no completion pulse.
//  - FSM IDLE: one action per cycle, priority EvictStart > FillStart > Inval > WE; losers dropped.
//    * WE & Hit: bytes of word[set][word] with ByteMask=1 updated, dirty<=1. WE on miss: no effect.
//    * Inval: V[set]<=0, dirty[set]<=0.
//    * FillStart: latch set, tag; counter<=0; ->FILL. V[set]<=0 same edge.
//    * EvictStart: if V&dirty of set, latch set, counter<=0, ->EVICT; else ignored (no Done).
//  - FILL: each FillValid cycle writes FillData to word[counter], counter++. Beats strictly in
//    order 0..BLOCKSIZE-1. On last beat: tag<=latched tag, V<=1, dirty<=0, ->IDLE, Done next cycle.
//    WE/Inval/starts ignored while in FILL. FillValid outside FILL ignored.
//  - EVICT: EvictValid=1, EvictData=word[latched set][counter]. Beat transfers when
//    EvictValid & EvictReady; counter++. Data held stable while EvictReady=0.
//    Last transfer: dirty<=0 (V unchanged), ->IDLE, EvictValid 0 next cycle, Done next cycle.
//  - Done is registered: high exactly the cycle after completing edge; Busy already 0 then.
//  - Counter width ob bits, wraps to 0 at completion; no other wrap reachable.
// TESTING
//  1 Reset: assert reset_n=0 async mid-cycle -> RV/Dirty/Hit/Busy/EvictValid 0 immediately.
//  2 Fill set 5, tag 0x12345, beats 0xA0..0xA3 with FillValid gaps -> Done 1 cycle after
//    4th beat; RD=0xA3_A2_A1_A0, RV=1, Dirty=0, Hit=1 at A=0x12345_050.
//  3 Hit write word 2 of set 5, WD=0xDEADBEEF, ByteMask=4'b0011 -> RWord=0x0000BEEF
//    over 0xA2 -> 0x0000BEEF (low bytes replaced, upper from 0x000000A2), Dirty=1; miss write: no change.
//  4 Evict set 5 with EvictReady toggling 1,0,1,1,0,1 -> 4 beats, EvictAddr 0x12345_050..05C,
//    data stable while stalled; Done then Dirty=0, RV=1.
//  5 EvictStart on clean line -> no Busy, no Done; EvictStart+FillStart same cycle -> evict only.
//  6 Reset asserted during beat 2 of fill -> IDLE, RV=0 for that set, no Done pulse.

Source files
------------

// File: rtl/writeback_cache_way_seq_if.sv
// CPU-side lookup/write, line fill and eviction stream signals of one cache way.
// The controller/bus side drives master; the way itself is the slave.
interface writeback_cache_way_seq_if #(
  parameter int TAGBITS   = 20,
  parameter int BLOCKSIZE = 4
);
  logic [31:0]             A;
  logic [31:0]             WD;
  logic [3:0]              ByteMask;
  logic                    WE;
  logic                    Inval;
  logic                    FillStart;
  logic [31:0]             FillData;
  logic                    FillValid;
  logic                    EvictStart;
  logic                    EvictReady;
  logic                    Hit;
  logic                    RV;
  logic                    Dirty;
  logic [TAGBITS-1:0]      RTag;
  logic [32*BLOCKSIZE-1:0] RD;
  logic [31:0]             RWord;
  logic                    Busy;
  logic                    Done;
  logic                    EvictValid;
  logic [31:0]             EvictData;
  logic [31:0]             EvictAddr;

  modport master (
    output A, WD, ByteMask, WE, Inval, FillStart, FillData, FillValid, EvictStart, EvictReady,
    input  Hit, RV, Dirty, RTag, RD, RWord, Busy, Done, EvictValid, EvictData, EvictAddr
  );

  modport slave (
    input  A, WD, ByteMask, WE, Inval, FillStart, FillData, FillValid, EvictStart, EvictReady,
    output Hit, RV, Dirty, RTag, RD, RWord, Busy, Done, EvictValid, EvictData, EvictAddr
  );
endinterface

// File: rtl/writeback_cache_way_seq.sv
// One write-back cache way with line fill and dirty eviction sequencing; lookup is combinational,
// fill/evict take one beat per FillValid / EvictValid&EvictReady cycle, Done one cycle after the last.
module writeback_cache_way_seq #(
  parameter int LINES     = 256,
  parameter int BLOCKSIZE = 4,
  parameter int TAGBITS   = 32 - $clog2(LINES) - $clog2(BLOCKSIZE) - 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  writeback_cache_way_seq_if.slave bus
);
  localparam int OB = $clog2(BLOCKSIZE);
  localparam int SB = $clog2(LINES);
  localparam logic [OB-1:0] LAST = OB'(BLOCKSIZE - 1);

  if (TAGBITS != 32 - SB - OB - 2) begin : g_tagbits_check
    $error("TAGBITS must equal 32 - clog2(LINES) - clog2(BLOCKSIZE) - 2");
  end

  typedef enum logic [1:0] {IDLE, FILL, EVICT} state_t;

  state_t                   state;
  logic [31:0]              data [LINES][BLOCKSIZE];
  logic [TAGBITS-1:0]       tags [LINES];
  logic [LINES-1:0]         valid;
  logic [LINES-1:0]         dirty;
  logic [SB-1:0]            lset;
  logic [TAGBITS-1:0]       ltag;
  logic [OB-1:0]            cnt;
  logic                     busy_q;
  logic                     done_q;
  logic                     evv_q;

  logic [OB-1:0]            a_word;
  logic [SB-1:0]            a_set;
  logic [TAGBITS-1:0]       a_tag;
  logic                     hit;
  logic                     cpu_wr;
  logic                     fill_beat;
  logic                     fill_last;
  logic [32*BLOCKSIZE-1:0]  rd_line;
  logic                     unused_a;

  assign a_word   = bus.A[OB+1:2];
  assign a_set    = bus.A[OB+SB+1:OB+2];
  assign a_tag    = bus.A[31:32-TAGBITS];
  assign unused_a = ^bus.A[1:0];

  assign hit       = valid[a_set] & (tags[a_set] == a_tag);
  // A CPU write only lands when no higher-priority request shares the cycle.
  assign cpu_wr    = (state == IDLE) & ~bus.EvictStart & ~bus.FillStart & ~bus.Inval & bus.WE & hit;
  assign fill_beat = (state == FILL) & bus.FillValid;
  assign fill_last = fill_beat & (cnt == LAST);

  always_comb begin
    rd_line = '0;
    for (int i = 0; i < BLOCKSIZE; i++) rd_line[32*i +: 32] = data[a_set][i];
  end

  assign bus.Hit        = hit;
  assign bus.RV         = valid[a_set];
  assign bus.Dirty      = dirty[a_set];
  assign bus.RTag       = tags[a_set];
  assign bus.RD         = rd_line;
  assign bus.RWord      = data[a_set][a_word];
  assign bus.Busy       = busy_q;
  assign bus.Done       = done_q;
  assign bus.EvictValid = evv_q;
  assign bus.EvictData  = data[lset][cnt];
  assign bus.EvictAddr  = {tags[lset], lset, cnt, 2'b00};

  // Data and tag storage carry no reset so they map onto plain RAM.
  always_ff @(posedge clk) begin
    if (fill_beat) data[lset][cnt] <= bus.FillData;
    for (int b = 0; b < 4; b++) begin
      if (cpu_wr && bus.ByteMask[b]) data[a_set][a_word][8*b +: 8] <= bus.WD[8*b +: 8];
    end
    if (fill_last) tags[lset] <= ltag;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      valid  <= '0;
      dirty  <= '0;
      lset   <= '0;
      ltag   <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      evv_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.EvictStart) begin
            // A clean or invalid line has nothing to write back.
            if (valid[a_set] && dirty[a_set]) begin
              lset   <= a_set;
              cnt    <= '0;
              state  <= EVICT;
              busy_q <= 1'b1;
              evv_q  <= 1'b1;
            end
          end else if (bus.FillStart) begin
            lset         <= a_set;
            ltag         <= a_tag;
            cnt          <= '0;
            valid[a_set] <= 1'b0;
            state        <= FILL;
            busy_q       <= 1'b1;
          end else if (bus.Inval) begin
            valid[a_set] <= 1'b0;
            dirty[a_set] <= 1'b0;
          end else if (cpu_wr) begin
            dirty[a_set] <= 1'b1;
          end
        end
        FILL: begin
          if (bus.FillValid) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              valid[lset] <= 1'b1;
              dirty[lset] <= 1'b0;
              state       <= IDLE;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end
          end
        end
        EVICT: begin
          if (bus.EvictReady) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              dirty[lset] <= 1'b0;
              state       <= IDLE;
              busy_q      <= 1'b0;
              evv_q       <= 1'b0;
              done_q      <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
